// File: rtl/logicalu_pkg.sv
// Shared opcodes, FSM encoding and helpers
// for the iterative logical/shift unit.
package logicalu_pkg;

  localparam logic [3:0] OP_LSR  = 4'b0000;
  localparam logic [3:0] OP_ASR  = 4'b0001;
  localparam logic [3:0] OP_MOVE = 4'b0010;
  localparam logic [3:0] OP_SWAP = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_ROR  = 4'b1001;
  localparam logic [3:0] OP_ROL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(
    input logic [3:0] f
  );
    return (f == OP_LSR) || (f == OP_ASR) ||
           (f == OP_LSL) || (f == OP_ROR) ||
           (f == OP_ROL);
  endfunction

endpackage

// File: rtl/logic_core.sv
// Single-cycle bitwise ops, half swap
// and illegal-opcode passthrough.
module logic_core
  import logicalu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             illegal_o
);

  localparam int H = WIDTH / 2;

  // decode the non-shift opcodes
  always_comb begin
    res_o     = a_i;
    illegal_o = 1'b0;
    case (func_i)
      OP_MOVE: res_o = a_i;
      OP_SWAP: res_o = {a_i[H-1:0], a_i[WIDTH-1:H]};
      OP_NOT:  res_o = ~a_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_LSR, OP_ASR, OP_LSL,
      OP_ROR, OP_ROL: res_o = a_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_logic_shift_unit.sv
// Multi-cycle logical/shift unit: one bit
// per cycle shifter behind valid/ready.
module seq_logic_shift_unit
  import logicalu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] leftOp,
  input  logic [WIDTH-1:0] rightOp,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] logicOut,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] core_res;
  logic             core_ill;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .func_i    (func),
    .a_i       (leftOp),
    .b_i       (rightOp),
    .res_o     (core_res),
    .illegal_o (core_ill)
  );

  // one-position move of the working register
  always_comb begin
    step_val = {1'b0, res_q[WIDTH-1:1]};
    step_bit = res_q[0];
    case (func_q)
      OP_ASR: begin
        step_val = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
        step_bit = res_q[0];
      end
      OP_LSL: begin
        step_val = {res_q[WIDTH-2:0], 1'b0};
        step_bit = res_q[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {res_q[0], res_q[WIDTH-1:1]};
        step_bit = res_q[0];
      end
      OP_ROL: begin
        step_val = {res_q[WIDTH-2:0], res_q[WIDTH-1]};
        step_bit = res_q[WIDTH-1];
      end
      default: begin
        step_val = {1'b0, res_q[WIDTH-1:1]};
        step_bit = res_q[0];
      end
    endcase
  end

  // next-state, datapath and flag updates
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    z_d     = z_q;
    n_d     = n_q;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          func_d = func;
          c_d    = 1'b0;
          if (is_shift(func)) begin
            res_d = leftOp;
            ill_d = 1'b0;
            if (amt == '0) begin
              z_d     = ~|leftOp;
              n_d     = leftOp[WIDTH-1];
              state_d = S_DONE;
            end else begin
              cnt_d   = amt;
              state_d = S_SHIFT;
            end
          end else begin
            res_d   = core_res;
            ill_d   = core_ill;
            z_d     = ~|core_res;
            n_d     = core_res[WIDTH-1];
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        res_d = step_val;
        c_d   = step_bit;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          z_d     = ~|step_val;
          n_d     = step_val[WIDTH-1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      func_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign logicOut  = res_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign illegal   = ill_q;

endmodule
